// File: rtl/spi_slave_pkg.sv
// Constants and types shared by the SPI slave receive and transmit shifters.
package spi_slave_pkg;

  localparam int unsigned SPI_CMD_LAST  = 7;  // last edge index of the 8-bit command
  localparam int unsigned QUAD_NIBBLE_W = 4;
  localparam int unsigned SPI_CNT_WIDTH = 8;

  typedef logic [SPI_CNT_WIDTH-1:0] spi_cnt_t;

endpackage

// File: rtl/spi_slave_rx_shifter.sv
// SPI slave receive shifter: samples MOSI (single or quad) on rising sclk and
// presents each completed segment as a word with a one-cycle data_ready pulse.
module spi_slave_rx_shifter
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  sdi0,
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic                  en_quad_in,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready
);

  logic [CNT_WIDTH-1:0]  counter_q, counter_d;
  logic [CNT_WIDTH-1:0]  trgt_q,    trgt_d;
  logic                  running_q, running_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  ready_q,   ready_d;
  logic                  active;
  logic                  seg_end;

  assign active  = running_q | counter_in_upd;
  assign seg_end = (counter_q == trgt_q);

  always_comb begin
    shift_d   = shift_q;
    counter_d = counter_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    trgt_d    = trgt_q;
    running_d = running_q;

    if (active) begin
      if (en_quad_in)
        shift_d = {shift_q[DATA_WIDTH-QUAD_NIBBLE_W-1:0], sdi3, sdi2, sdi1, sdi0};
      else
        shift_d = {shift_q[DATA_WIDTH-2:0], sdi0};

      if (seg_end) begin
        counter_d = '0;
        data_d    = shift_d;
        ready_d   = 1'b1;
      end else begin
        counter_d = counter_q + CNT_WIDTH'(1);
      end
    end

    // Re-arming wins over a segment end on the same edge.
    if (counter_in_upd) begin
      trgt_d    = counter_in;
      running_d = 1'b1;
    end else if (seg_end) begin
      running_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      counter_q <= '0;
      trgt_q    <= CNT_WIDTH'(SPI_CMD_LAST);
      running_q <= 1'b1;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      counter_q <= counter_d;
      trgt_q    <= trgt_d;
      running_q <= running_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
    end
  end

  assign data       = data_q;
  assign data_ready = ready_q;

endmodule
